// File: rtl/utopia_rx_cell_assembler_pkg.sv
// rtl/utopia_rx_cell_assembler_pkg.sv - shared UNI cell types, constants and HEC CRC helper
package utopia_pkg;

  localparam int         CellBytes = 53;
  localparam int         CellBits  = CellBytes * 8;
  localparam logic [7:0] HecCoset  = 8'h55;

  typedef struct packed {
    logic [3:0]       gfc;
    logic [7:0]       vpi;
    logic [15:0]      vci;
    logic [2:0]       pt;
    logic             clp;
    logic [7:0]       hec;
    logic [47:0][7:0] payload;
  } uni_cell_t;

  typedef enum logic [1:0] {
    RX_HUNT    = 2'd0,
    RX_RECV    = 2'd1,
    RX_DISCARD = 2'd2,
    RX_STALL   = 2'd3
  } rx_state_e;

  // CRC-8, x^8+x^2+x+1, init 0, header bits taken MSB first
  function automatic logic [7:0] hec_crc8(input logic [31:0] hdr);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      if (crc[7] ^ hdr[i]) begin
        crc = {crc[6:0], 1'b0} ^ 8'h07;
      end else begin
        crc = {crc[6:0], 1'b0};
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/utopia_rx_cell_assembler_if.sv
// rtl/utopia_rx_cell_assembler_if.sv - Utopia L1 receive port plus assembled-cell output handshake
interface utopia_rx_cell_assembler_if;
  import utopia_pkg::*;

  logic [7:0]          rx_data;
  logic                rx_soc;
  logic                rx_clav;
  logic                rx_en_n;
  logic [CellBits-1:0] out_cell;
  logic                out_valid;
  logic                out_ready;

  modport master (
    input  rx_data, rx_soc, rx_clav, out_ready,
    output rx_en_n, out_cell, out_valid
  );

  modport slave (
    output rx_data, rx_soc, rx_clav, out_ready,
    input  rx_en_n, out_cell, out_valid
  );

endinterface

// File: rtl/hec_crc8_check.sv
// rtl/hec_crc8_check.sv - combinational HEC check of a received header byte against bytes 0-3
module hec_crc8_check
  import utopia_pkg::*;
#(
  parameter logic [7:0] Coset = 8'h55
) (
  input  logic [31:0] hdr_i,
  input  logic [7:0]  hec_i,
  output logic        hec_ok_o
);

  assign hec_ok_o = ((hec_crc8(hdr_i) ^ Coset) == hec_i);

endmodule

// File: rtl/utopia_rx_cell_assembler.sv
// rtl/utopia_rx_cell_assembler.sv - Utopia L1 receive master: cell framing, HEC check, output hold
module utopia_rx_cell_assembler
  import utopia_pkg::*;
#(
  parameter int         CellBytes = 53,
  parameter logic [7:0] HecCoset  = 8'h55,
  parameter int         CntW      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  utopia_rx_cell_assembler_if.master bus,
  output logic [CntW-1:0]            good_cnt,
  output logic [7:0]                 hec_err_cnt,
  output logic [7:0]                 runt_cnt
);

  localparam int         CellW   = CellBytes * 8;
  localparam logic [5:0] LastIdx = 6'(CellBytes - 1);
  localparam logic [5:0] HecIdx  = 6'd4;

  localparam logic [1:0] ST_HUNT    = RX_HUNT;
  localparam logic [1:0] ST_RECV    = RX_RECV;
  localparam logic [1:0] ST_DISCARD = RX_DISCARD;
  localparam logic [1:0] ST_STALL   = RX_STALL;

  logic [1:0]                 state_q, state_d;
  logic [5:0]                 idx_q, idx_d;
  logic [CellBytes-1:0][7:0]  asm_q, asm_d;
  logic [CellW-1:0]           cell_q, cell_d;
  logic                       valid_q, valid_d;
  logic                       en_n_q, en_n_d;
  logic [CntW-1:0]            good_q, good_d;
  logic [7:0]                 hec_q, hec_d;
  logic [7:0]                 runt_q, runt_d;

  logic cap;
  logic out_free;
  logic hec_ok;

  assign cap      = !en_n_q && bus.rx_clav;
  assign out_free = !valid_q || bus.out_ready;

  hec_crc8_check #(.Coset(HecCoset)) u_hec (
    .hdr_i    (asm_q[CellBytes-1 -: 4]),
    .hec_i    (bus.rx_data),
    .hec_ok_o (hec_ok)
  );

  // Byte 0 of the cell lives in the top element so asm_q maps straight onto out_cell
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    cell_d  = cell_q;
    valid_d = valid_q;
    en_n_d  = 1'b0;
    good_d  = good_q;
    hec_d   = hec_q;
    runt_d  = runt_q;

    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_HUNT: begin
        if (cap && bus.rx_soc) begin
          asm_d[LastIdx] = bus.rx_data;
          idx_d          = 6'd1;
          state_d        = ST_RECV;
        end
      end
      ST_RECV: begin
        if (cap) begin
          if (bus.rx_soc) begin
            runt_d         = (runt_q == 8'hFF) ? runt_q : runt_q + 8'd1;
            asm_d[LastIdx] = bus.rx_data;
            idx_d          = 6'd1;
          end else begin
            asm_d[LastIdx - idx_q] = bus.rx_data;
            if (idx_q == HecIdx && !hec_ok) begin
              hec_d   = (hec_q == 8'hFF) ? hec_q : hec_q + 8'd1;
              idx_d   = idx_q + 6'd1;
              state_d = ST_DISCARD;
            end else if (idx_q == LastIdx) begin
              idx_d = 6'd0;
              if (out_free) begin
                cell_d  = asm_d;
                valid_d = 1'b1;
                good_d  = good_q + CntW'(1);
                state_d = ST_HUNT;
              end else begin
                en_n_d  = 1'b1;
                state_d = ST_STALL;
              end
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (cap) begin
          if (bus.rx_soc) begin
            asm_d[LastIdx] = bus.rx_data;
            idx_d          = 6'd1;
            state_d        = ST_RECV;
          end else if (idx_q == LastIdx) begin
            idx_d   = 6'd0;
            state_d = ST_HUNT;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_STALL: begin
        // Enable stays high through the exit cycle so the PHY restarts one edge later
        en_n_d = 1'b1;
        if (out_free) begin
          cell_d  = asm_q;
          valid_d = 1'b1;
          good_d  = good_q + CntW'(1);
          state_d = ST_HUNT;
        end
      end
      default: begin
        state_d = ST_HUNT;
        idx_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HUNT;
      idx_q   <= 6'd0;
      asm_q   <= '0;
      cell_q  <= '0;
      valid_q <= 1'b0;
      en_n_q  <= 1'b1;
      good_q  <= '0;
      hec_q   <= 8'd0;
      runt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      cell_q  <= cell_d;
      valid_q <= valid_d;
      en_n_q  <= en_n_d;
      good_q  <= good_d;
      hec_q   <= hec_d;
      runt_q  <= runt_d;
    end
  end

  assign bus.rx_en_n   = en_n_q;
  assign bus.out_cell  = cell_q;
  assign bus.out_valid = valid_q;
  assign good_cnt      = good_q;
  assign hec_err_cnt   = hec_q;
  assign runt_cnt      = runt_q;

endmodule

// File: tb/tb_utopia_rx_cell_assembler.sv
// tb/tb_utopia_rx_cell_assembler.sv - scoreboard bench with PHY driver, cell-level model and output monitor
module tb_utopia_rx_cell_assembler;
  import utopia_pkg::*;

  typedef logic [7:0] cell_bytes_t [53];

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] good_cnt;
  logic [7:0]  hec_err_cnt;
  logic [7:0]  runt_cnt;

  utopia_rx_cell_assembler_if bus();

  utopia_rx_cell_assembler #(
    .CellBytes (53),
    .HecCoset  (8'h55),
    .CntW      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .good_cnt    (good_cnt),
    .hec_err_cnt (hec_err_cnt),
    .runt_cnt    (runt_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]   phy_q[$];
  logic [423:0] exp_q[$];
  int bytes_taken = 0;
  int clav_mode   = 0;
  int ready_mode  = 0;
  int exp_good    = 0;
  int exp_hec     = 0;
  int exp_runt    = 0;

  task automatic check_eq(input string name, input logic [423:0] act, input logic [423:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ref_hec(input logic [31:0] hdr);
    logic [39:0] r;
    r = {hdr, 8'h00};
    for (int i = 39; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic logic [423:0] pack_cell(input cell_bytes_t b);
    logic [423:0] v;
    for (int i = 0; i < 53; i++) v[423 - 8*i -: 8] = b[i];
    return v;
  endfunction

  function automatic int sat255(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // A segment starts with SOC; its fate is decided from its length and header alone
  task automatic send_segment(input logic [31:0] hdr, input logic [7:0] hec_xor,
                              input int len, input bit ramp);
    cell_bytes_t b;
    b[0] = hdr[31:24];
    b[1] = hdr[23:16];
    b[2] = hdr[15:8];
    b[3] = hdr[7:0];
    b[4] = ref_hec(hdr) ^ 8'h55 ^ hec_xor;
    for (int i = 5; i < 53; i++) b[i] = ramp ? 8'(i - 5) : 8'($urandom);
    for (int i = 0; i < len; i++) phy_q.push_back({(i == 0), b[i]});
    if (len == 53) begin
      if (hec_xor == 8'h00) begin
        exp_q.push_back(pack_cell(b));
        exp_good++;
      end else begin
        exp_hec++;
      end
    end else if (hec_xor != 8'h00 && len >= 5) begin
      exp_hec++;
    end else begin
      exp_runt++;
    end
  endtask

  task automatic wait_bytes(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (bytes_taken < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bytes_taken < target) begin
      n_fail++;
      $display("FAIL %s_timeout: captured %0d bytes, required %0d", name, bytes_taken, target);
    end
  endtask

  task automatic wait_drained(input string name, input int budget);
    int k;
    k = 0;
    while ((phy_q.size() != 0 || exp_q.size() != 0 || bus.out_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d cycles, pending bytes %0d cells %0d, required empty",
               name, k, phy_q.size(), exp_q.size());
    end
  endtask

  task automatic check_counts(input string name);
    check_eq({name, "_good_cnt"}, 424'(good_cnt), 424'(16'(exp_good)));
    check_eq({name, "_hec_err_cnt"}, 424'(hec_err_cnt), 424'(sat255(exp_hec)));
    check_eq({name, "_runt_cnt"}, 424'(runt_cnt), 424'(sat255(exp_runt)));
  endtask

  // PHY model: byte at the head of phy_q is offered until the DUT takes it
  initial begin : phy_driver
    logic alt;
    logic clav;
    logic will_cap;
    alt = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_soc  = 1'b0;
    bus.rx_clav = 1'b0;
    forever begin
      @(negedge clk);
      alt = ~alt;
      case (clav_mode)
        0:       clav = 1'b1;
        1:       clav = alt;
        default: clav = ($urandom_range(0, 3) != 0);
      endcase
      if (phy_q.size() == 0) begin
        bus.rx_data = 8'($urandom);
        bus.rx_soc  = 1'b0;
        bus.rx_clav = 1'b0;
      end else begin
        bus.rx_data = phy_q[0][7:0];
        bus.rx_soc  = phy_q[0][8];
        bus.rx_clav = clav;
      end
      will_cap = !bus.rx_en_n && bus.rx_clav && (phy_q.size() != 0);
      @(posedge clk);
      if (will_cap && phy_q.size() != 0) begin
        void'(phy_q.pop_front());
        bytes_taken++;
      end
    end
  end

  // Output monitor: drives out_ready and scores every handshake
  initial begin : monitor
    logic         held;
    logic [423:0] held_cell;
    held = 1'b0;
    held_cell = '0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst && held) begin
        check_eq("out_valid_held", 424'(bus.out_valid), 424'(1));
        check_eq("out_cell_stable", bus.out_cell, held_cell);
      end
      if (rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_cell: actual %0h required none", bus.out_cell);
        end else begin
          check_eq("cell_data", bus.out_cell, exp_q.pop_front());
        end
      end
      held      = rst && bus.out_valid && !bus.out_ready;
      held_cell = bus.out_cell;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int start;
    int kind;
    int njunk;
    bit prev_full;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_rx_en_n", 424'(bus.rx_en_n), 424'(1));
    check_eq("reset_out_valid", 424'(bus.out_valid), 424'(0));
    check_eq("reset_out_cell", bus.out_cell, 424'(0));
    check_counts("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rx_en_n_after_reset", 424'(bus.rx_en_n), 424'(0));

    // Single reference cell: header 00000000, HEC 55, payload 00..2F
    start = bytes_taken;
    send_segment(32'h0000_0000, 8'h00, 53, 1'b1);
    wait_bytes("single_52", start + 52, 200);
    check_eq("single_no_early_valid", 424'(bus.out_valid), 424'(0));
    wait_bytes("single_53", start + 53, 20);
    check_eq("single_latency", 424'(bus.out_valid), 424'(1));
    wait_drained("single", 200);
    check_counts("single");

    // HEC byte 0x54 is dropped, the next good cell still comes through
    send_segment(32'h0000_0000, 8'h01, 53, 1'b1);
    send_segment($urandom, 8'h00, 53, 1'b0);
    wait_drained("hec_err", 400);
    check_counts("hec_err");

    // SOC at byte 20 cuts the first cell short
    send_segment($urandom, 8'h00, 20, 1'b0);
    send_segment($urandom, 8'h00, 53, 1'b0);
    wait_drained("runt", 400);
    check_counts("runt");

    // Core stalled across three back-to-back cells
    ready_mode = 1;
    start = bytes_taken;
    for (int c = 0; c < 3; c++) send_segment($urandom, 8'h00, 53, 1'b0);
    wait_bytes("stall", start + 106, 400);
    repeat (3) @(negedge clk);
    check_eq("stall_rx_en_n", 424'(bus.rx_en_n), 424'(1));
    check_eq("stall_out_valid", 424'(bus.out_valid), 424'(1));
    check_eq("stall_no_capture", 424'(bytes_taken), 424'(start + 106));
    check_eq("stall_good_cnt", 424'(good_cnt), 424'(16'(exp_good - 2)));
    ready_mode = 0;
    wait_drained("stall", 600);
    check_counts("stall");

    // rx_clav alternating every cycle
    clav_mode = 1;
    send_segment($urandom, 8'h00, 53, 1'b1);
    send_segment($urandom, 8'h00, 53, 1'b0);
    wait_drained("clav_alt", 600);
    check_counts("clav_alt");

    // Randomized mix of good, bad-HEC and runt cells with junk and backpressure
    clav_mode = 2;
    ready_mode = 2;
    prev_full = 1'b1;
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 9);
      if (prev_full && $urandom_range(0, 1) == 1) begin
        njunk = $urandom_range(1, 3);
        for (int j = 0; j < njunk; j++) phy_q.push_back({1'b0, 8'($urandom)});
      end
      if (kind <= 5) begin
        send_segment($urandom, 8'h00, 53, 1'b0);
        prev_full = 1'b1;
      end else if (kind <= 7) begin
        send_segment($urandom, 8'($urandom_range(1, 255)), 53, 1'b0);
        prev_full = 1'b1;
      end else begin
        send_segment($urandom, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00,
                     $urandom_range(1, 52), 1'b0);
        prev_full = 1'b0;
      end
    end
    if (!prev_full) send_segment($urandom, 8'h00, 53, 1'b0);
    wait_drained("random", 20000);
    check_counts("random");

    // Reset with one cell held at the output and another 30 bytes in
    clav_mode = 0;
    ready_mode = 1;
    start = bytes_taken;
    send_segment($urandom, 8'h00, 53, 1'b0);
    send_segment($urandom, 8'h00, 53, 1'b0);
    wait_bytes("reset_mid", start + 83, 400);
    @(posedge clk);
    #2;
    rst = 1'b0;
    phy_q.delete();
    exp_q.delete();
    exp_good = 0;
    exp_hec  = 0;
    exp_runt = 0;
    #1;
    check_eq("reset_mid_rx_en_n", 424'(bus.rx_en_n), 424'(1));
    check_eq("reset_mid_out_valid", 424'(bus.out_valid), 424'(0));
    check_counts("reset_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ready_mode = 0;
    send_segment($urandom, 8'h00, 53, 1'b0);
    wait_drained("after_reset", 400);
    check_counts("after_reset");

    // Saturation of both error counters
    for (int s = 0; s < 260; s++) send_segment($urandom, 8'h80, 5, 1'b0);
    for (int s = 0; s < 260; s++) send_segment($urandom, 8'h00, 2, 1'b0);
    send_segment($urandom, 8'h00, 53, 1'b0);
    wait_drained("saturate", 4000);
    check_counts("saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
